// File: rtl/mem_if_pkg.sv
// Shared types and header layout for the memory-interface command port,
// used by both the host-side issuer and the receiver.
package mem_if_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        HDR      = 3'd2,
        DATA     = 3'd3,
        ACK_WAIT = 3'd4
    } state_t;

    localparam logic [1:0] DEST_FSM    = 2'b00;
    localparam logic [1:0] DEST_QSPI   = 2'b01;
    localparam logic [1:0] DEST_STATUS = 2'b10;

    localparam int HDR_BYTES = 5;

    localparam int RW_BIT   = 7;
    localparam int DEST_MSB = 6;
    localparam int DEST_LSB = 5;
    localparam int LEN8_BIT = 0;

    // Header byte idx of a command, most significant field first
    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic        rw,
                                            input logic [1:0]  dest,
                                            input logic [8:0]  len,
                                            input logic [23:0] addr);
        logic [7:0] b0;
        b0                    = 8'h00;
        b0[RW_BIT]            = rw;
        b0[DEST_MSB:DEST_LSB] = dest;
        b0[LEN8_BIT]          = len[8];
        case (idx)
            3'd0:    hdr_byte = b0;
            3'd1:    hdr_byte = len[7:0];
            3'd2:    hdr_byte = addr[23:16];
            3'd3:    hdr_byte = addr[15:8];
            3'd4:    hdr_byte = addr[7:0];
            default: hdr_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mem_if_timeout.sv
// Loadable up-counter whose expired flag is high while the count equals limit.
module mem_if_timeout #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_r;

    // Load takes priority over counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (enable) begin
            count_r <= count_r + WIDTH'(1);
        end
    end

    assign expired = (count_r == limit);

endmodule

// File: rtl/mem_cmd_issuer.sv
// Host-side command issuer: serializes a parallel command onto the 8-bit
// valid/ready command bus, streams write payload, then waits for its ack.
module mem_cmd_issuer
    import mem_if_pkg::*;
#(
    parameter logic [1:0] ACK_ID         = 2'd1,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [1:0]  cmd_dest,
    input  logic [8:0]  cmd_len,
    input  logic [23:0] cmd_addr,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic        drive_bus,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [7:0]  bus_data,
    input  logic        ack_valid,
    input  logic [1:0]  ack_id,
    output logic        busy,
    output logic        done,
    output logic        err_timeout
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(HDR_BYTES - 1);

    state_t      state_r;
    logic        rw_r;
    logic [1:0]  dest_r;
    logic [8:0]  len_r;
    logic [23:0] addr_r;
    logic [2:0]  hdr_idx_r;
    logic [8:0]  data_cnt_r;
    logic        cmd_ready_r;
    logic        bus_req_r;
    logic        drive_bus_r;
    logic        hdr_valid_r;
    logic [7:0]  hdr_data_r;
    logic        in_data_r;
    logic        busy_r;
    logic        done_r;
    logic        err_timeout_r;

    logic        tmo_expired_s;
    logic        ack_match_s;

    mem_if_timeout #(.WIDTH(16)) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state_r != ACK_WAIT),
        .load_value (16'd0),
        .enable     (state_r == ACK_WAIT),
        .limit      (TMO_LIMIT),
        .expired    (tmo_expired_s)
    );

    assign ack_match_s = ack_valid && (ack_id == ACK_ID);

    // Command sequencer; a matching ack wins over a simultaneous timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            rw_r          <= 1'b0;
            dest_r        <= 2'b00;
            len_r         <= 9'd0;
            addr_r        <= 24'd0;
            hdr_idx_r     <= 3'd0;
            data_cnt_r    <= 9'd0;
            cmd_ready_r   <= 1'b1;
            bus_req_r     <= 1'b0;
            drive_bus_r   <= 1'b0;
            hdr_valid_r   <= 1'b0;
            hdr_data_r    <= 8'h00;
            in_data_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            done_r        <= 1'b0;
            err_timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        rw_r        <= cmd_rw;
                        dest_r      <= cmd_dest;
                        len_r       <= cmd_len;
                        addr_r      <= cmd_addr;
                        cmd_ready_r <= 1'b0;
                        bus_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= REQ;
                    end
                end
                REQ: begin
                    if (bus_grant) begin
                        drive_bus_r <= 1'b1;
                        hdr_valid_r <= 1'b1;
                        hdr_idx_r   <= 3'd0;
                        hdr_data_r  <= hdr_byte(3'd0, rw_r, dest_r, len_r, addr_r);
                        state_r     <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_valid_r && bus_ready) begin
                        if (hdr_idx_r == LAST_IDX) begin
                            hdr_valid_r <= 1'b0;
                            hdr_data_r  <= 8'h00;
                            hdr_idx_r   <= 3'd0;
                            if (rw_r && (len_r != 9'd0)) begin
                                data_cnt_r <= len_r;
                                in_data_r  <= 1'b1;
                                state_r    <= DATA;
                            end else begin
                                bus_req_r   <= 1'b0;
                                drive_bus_r <= 1'b0;
                                state_r     <= ACK_WAIT;
                            end
                        end else begin
                            hdr_idx_r  <= hdr_idx_r + 3'd1;
                            hdr_data_r <= hdr_byte(hdr_idx_r + 3'd1, rw_r, dest_r, len_r, addr_r);
                        end
                    end
                end
                DATA: begin
                    if (wr_valid && bus_ready) begin
                        data_cnt_r <= data_cnt_r - 9'd1;
                        if (data_cnt_r == 9'd1) begin
                            in_data_r   <= 1'b0;
                            bus_req_r   <= 1'b0;
                            drive_bus_r <= 1'b0;
                            state_r     <= ACK_WAIT;
                        end
                    end
                end
                ACK_WAIT: begin
                    if (ack_match_s) begin
                        done_r      <= 1'b1;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else if (tmo_expired_s) begin
                        err_timeout_r <= 1'b1;
                        cmd_ready_r   <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Payload is forwarded with zero latency; header bytes come from registers
    always_comb begin
        if (in_data_r) begin
            bus_valid = wr_valid;
            wr_ready  = bus_ready;
            bus_data  = wr_data;
        end else begin
            bus_valid = hdr_valid_r;
            wr_ready  = 1'b0;
            bus_data  = hdr_data_r;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign bus_req     = bus_req_r;
    assign drive_bus   = drive_bus_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_mem_cmd_issuer.sv
// Directed bench for mem_cmd_issuer: header bytes, payload forwarding,
// ack/timeout handling, mid-transfer reset and delayed grant.
module tb_mem_cmd_issuer;
    import mem_if_pkg::*;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [1:0]  cmd_dest;
    logic [8:0]  cmd_len;
    logic [23:0] cmd_addr;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_data;
    logic        bus_req, bus_grant, drive_bus, bus_valid, bus_ready;
    logic [7:0]  bus_data;
    logic        ack_valid;
    logic [1:0]  ack_id;
    logic        busy, done, err_timeout;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          pidx     = 0;
    int          ncyc;
    logic        wr_seen;
    logic [7:0]  payload [512];
    logic [7:0]  rx [$];
    logic [7:0]  exp_q [$];

    mem_cmd_issuer #(.ACK_ID(2'd1), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dest(cmd_dest), .cmd_len(cmd_len), .cmd_addr(cmd_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .bus_req(bus_req), .bus_grant(bus_grant), .drive_bus(drive_bus),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_data(bus_data),
        .ack_valid(ack_valid), .ack_id(ack_id),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic start_test();
        rx.delete();
        exp_q.delete();
        pidx    = 0;
        wr_seen = 1'b0;
    endtask

    task automatic push_hdr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
        exp_q.push_back(b3); exp_q.push_back(b4);
    endtask

    // Present a command in IDLE, then scramble cmd_* to prove they were latched
    task automatic issue(input logic rw, input logic [1:0] dest, input logic [8:0] len, input logic [23:0] addr);
        cmd_rw = rw; cmd_dest = dest; cmd_len = len; cmd_addr = addr; cmd_valid = 1'b1;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        tick();
        cmd_valid = 1'b0; cmd_rw = ~rw; cmd_dest = ~dest; cmd_len = ~len; cmd_addr = ~addr;
        #1;
        chk("req_bus_req", bus_req, 1);
        chk("req_cmd_ready", cmd_ready, 0);
        chk("req_busy", busy, 1);
        chk("req_drive_bus", drive_bus, 0);
        chk("req_bus_valid", bus_valid, 0);
    endtask

    // Act as bus receiver and payload source until nbytes beats complete
    task automatic xfer(input int nbytes, input bit stalls, input bit ack_noise, input int budget, output int cycles);
        int         got;
        logic       prev_stall;
        logic [7:0] prev_data;
        got = 0; cycles = 0; prev_stall = 1'b0; prev_data = 8'h00;
        while (got < nbytes && cycles < budget) begin
            bus_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr_valid  = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_data   = payload[pidx];
            ack_valid = ack_noise;
            ack_id    = 2'd1;
            #1;
            if (wr_ready) wr_seen = 1'b1;
            if (prev_stall) begin
                chk("hdr_hold_valid", bus_valid, 1);
                chk("hdr_hold_data", bus_data, prev_data);
            end
            prev_stall = (got < HDR_BYTES) && bus_valid && !bus_ready;
            prev_data  = bus_data;
            if (bus_valid && bus_ready) begin
                rx.push_back(bus_data);
                got++;
            end
            if (wr_valid && wr_ready && pidx < 511) pidx++;
            tick();
            cycles++;
        end
        bus_ready = 1'b0; wr_valid = 1'b0; ack_valid = 1'b0;
        chk("xfer_beats", got, nbytes);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_size"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) chk(tag, rx[i], exp_q[i]);
    endtask

    task automatic check_bus_released(input string tag);
        bus_ready = 1'b1;
        #1;
        chk({tag, "_bus_valid"}, bus_valid, 0);
        chk({tag, "_drive_bus"}, drive_bus, 0);
        chk({tag, "_bus_req"}, bus_req, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_busy"}, busy, 1);
        bus_ready = 1'b0;
    endtask

    task automatic ack_done(input int gap);
        repeat (gap) begin
            #1;
            chk("wait_done_low", done, 0);
            tick();
        end
        ack_valid = 1'b1; ack_id = 2'd1;
        tick();
        ack_valid = 1'b0;
        #1;
        chk("ack_done", done, 1);
        chk("ack_err", err_timeout, 0);
        chk("ack_busy", busy, 0);
        chk("ack_cmd_ready", cmd_ready, 1);
        tick();
        chk("done_one_pulse", done, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) payload[i] = 8'(i * 7 + 3);
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dest = 2'b00; cmd_len = 9'd0;
        cmd_addr = 24'd0; wr_valid = 1'b0; wr_data = 8'h00; bus_grant = 1'b1;
        bus_ready = 1'b0; ack_valid = 1'b0; ack_id = 2'd0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_drive_bus", drive_bus, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_bus_data", bus_data, 0);

        // Read, no stalls: header on five consecutive cycles
        start_test();
        issue(1'b0, DEST_QSPI, 9'h010, 24'h123456);
        tick();
        push_hdr(8'h20, 8'h10, 8'h12, 8'h34, 8'h56);
        xfer(5, 1'b0, 1'b0, 50, ncyc);
        chk("rd_consecutive", ncyc, 5);
        check_rx("rd_hdr");
        check_bus_released("rd_end");
        ack_done(3);

        // Long write with stalls; acks during transfer must be dropped
        start_test();
        issue(1'b1, DEST_FSM, 9'h103, 24'hABCDEF);
        tick();
        push_hdr(8'h81, 8'h03, 8'hAB, 8'hCD, 8'hEF);
        for (int i = 0; i < 259; i++) exp_q.push_back(payload[i]);
        xfer(264, 1'b1, 1'b1, 4000, ncyc);
        check_rx("wr_stream");
        check_bus_released("wr_end");
        ack_done(1);

        // Zero-length write: header only, wr_ready never seen
        start_test();
        issue(1'b1, DEST_FSM, 9'd0, 24'h13579B);
        tick();
        push_hdr(8'h80, 8'h00, 8'h13, 8'h57, 8'h9B);
        xfer(5, 1'b0, 1'b0, 50, ncyc);
        check_rx("wr0_hdr");
        check_bus_released("wr0_end");
        ack_done(2);
        chk("wr0_no_wr_ready", wr_seen, 0);

        // Foreign acks then silence: timeout TMO cycles after entering ACK_WAIT
        start_test();
        issue(1'b0, DEST_QSPI, 9'd3, 24'h000010);
        tick();
        push_hdr(8'h20, 8'h03, 8'h00, 8'h00, 8'h10);
        xfer(5, 1'b1, 1'b0, 200, ncyc);
        check_rx("tmo_hdr");
        for (int k = 0; k < TMO; k++) begin
            ack_valid = (k < 10); ack_id = 2'd2;
            #1;
            chk("tmo_wait_err", err_timeout, 0);
            chk("tmo_wait_done", done, 0);
            chk("tmo_wait_busy", busy, 1);
            tick();
        end
        ack_valid = 1'b0;
        chk("tmo_err_pulse", err_timeout, 1);
        chk("tmo_no_done", done, 0);
        chk("tmo_busy", busy, 0);
        chk("tmo_cmd_ready", cmd_ready, 1);
        tick();
        chk("tmo_err_one_pulse", err_timeout, 0);

        // Matching ack on the expiry cycle wins
        start_test();
        issue(1'b0, DEST_FSM, 9'd1, 24'h000020);
        tick();
        xfer(5, 1'b0, 1'b0, 50, ncyc);
        for (int k = 0; k < TMO - 1; k++) begin
            #1;
            chk("race_wait_err", err_timeout, 0);
            tick();
        end
        ack_valid = 1'b1; ack_id = 2'd1;
        tick();
        ack_valid = 1'b0;
        chk("race_done", done, 1);
        chk("race_no_err", err_timeout, 0);
        tick();
        chk("race_err_after", err_timeout, 0);

        // Reset during payload beat 7, then a fresh command
        start_test();
        issue(1'b1, DEST_QSPI, 9'd20, 24'h000102);
        tick();
        push_hdr(8'hA0, 8'h14, 8'h00, 8'h01, 8'h02);
        for (int i = 0; i < 7; i++) exp_q.push_back(payload[i]);
        xfer(12, 1'b0, 1'b0, 50, ncyc);
        check_rx("mid_rst_pre");
        wr_valid = 1'b1; bus_ready = 1'b1; wr_data = payload[7]; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_cmd_ready", cmd_ready, 1);
        chk("mrst_bus_req", bus_req, 0);
        chk("mrst_drive_bus", drive_bus, 0);
        chk("mrst_bus_valid", bus_valid, 0);
        chk("mrst_wr_ready", wr_ready, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", err_timeout, 0);
        chk("mrst_bus_data", bus_data, 0);
        wr_valid = 1'b0; bus_ready = 1'b0;
        start_test();
        issue(1'b0, DEST_STATUS, 9'd5, 24'h00FF01);
        tick();
        push_hdr(8'h40, 8'h05, 8'h00, 8'hFF, 8'h01);
        xfer(5, 1'b0, 1'b0, 50, ncyc);
        check_rx("fresh_hdr");
        ack_done(0);

        // Grant withheld for 20 cycles, then dropped right after it is seen
        start_test();
        bus_grant = 1'b0;
        issue(1'b0, 2'b11, 9'h1FF, 24'h800001);
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("nogrant_bus_req", bus_req, 1);
            chk("nogrant_drive_bus", drive_bus, 0);
            chk("nogrant_bus_valid", bus_valid, 0);
            tick();
        end
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        chk("grant_drive_bus", drive_bus, 1);
        chk("grant_bus_valid", bus_valid, 1);
        chk("grant_b0", bus_data, 8'h61);
        push_hdr(8'h61, 8'hFF, 8'h80, 8'h00, 8'h01);
        xfer(5, 1'b1, 1'b0, 200, ncyc);
        check_rx("grant_hdr");
        check_bus_released("grant_end");
        ack_done(1);
        bus_grant = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
